// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : spi_pkg
//  Description : Shared types and constants for the SPI master that drives
//                the single-clock SPI slave/RAM wrapper.
//                - opcode_e : 2-bit command opcode carried in cmd[9:8]
//                - state_e  : master frame sequencer states
//                - CMD_W / DATA_W : command and reply widths
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int CMD_W  = 10;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_SHIFT_OUT = 3'd2,
        ST_WAIT_RD   = 3'd3,
        ST_SHIFT_IN  = 3'd4,
        ST_END       = 3'd5
    } state_e;

    // Largest of three values; sizes the shared gap/latency counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master
//  Description : SPI initiator. Accepts 10-bit command words from a host via
//                a valid/ready handshake, frames them MSB first on SS_n/MOSI
//                and, for read-data commands (opcode 2'b11), captures the
//                8-bit MISO reply and returns it with a one-cycle pulse.
//  Ports       :
//    clk        in   clock, all logic on posedge
//    rst_n      in   synchronous active-low reset
//    cmd_valid  in   host presents a command
//    cmd_data   in   [9:8] opcode, [7:0] address/data
//    cmd_ready  out  high only while idle
//    MISO       in   serial data from slave
//    MOSI       out  serial data to slave
//    SS_n       out  active-low frame select
//    rd_valid   out  one-cycle pulse qualifying rd_data
//    rd_data    out  captured reply byte, held until next read completes
//    busy       out  high in every state except idle
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_master
    import spi_pkg::*;
#(
    parameter int GAP_CYCLES = 1,
    parameter int RD_LATENCY = 2,
    parameter int IDLE_GAP   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    input  logic [CMD_W-1:0]  cmd_data,
    output logic              cmd_ready,
    input  logic              MISO,
    output logic              MOSI,
    output logic              SS_n,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy
);

    localparam int c_cnt_max = max3(GAP_CYCLES, RD_LATENCY, IDLE_GAP);
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

    localparam logic [c_cnt_w-1:0] c_gap_last  = c_cnt_w'(GAP_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_lat_last  = c_cnt_w'(RD_LATENCY - 1);
    localparam logic [c_cnt_w-1:0] c_idle_last = c_cnt_w'(IDLE_GAP - 1);
    localparam logic [3:0]         c_out_last  = 4'(CMD_W - 1);
    localparam logic [3:0]         c_in_last   = 4'(DATA_W - 1);

    // Zero-length phases would make the sequencer skip states entirely.
    if (GAP_CYCLES < 1) begin : g_chk_gap
        $error("spi_master: GAP_CYCLES must be at least 1");
    end
    if (RD_LATENCY < 1) begin : g_chk_lat
        $error("spi_master: RD_LATENCY must be at least 1");
    end
    if (IDLE_GAP < 1) begin : g_chk_idle
        $error("spi_master: IDLE_GAP must be at least 1");
    end

    state_e               r_state;
    state_e               w_state_next;
    logic [c_cnt_w-1:0]   r_gap_cnt;
    logic [3:0]           r_bit_cnt;
    logic [CMD_W-1:0]     r_cmd;
    logic [DATA_W-1:0]    r_shift_in;
    logic [DATA_W-1:0]    r_rd_data;
    logic                 r_rd_valid;
    logic                 w_accept;
    opcode_e              w_op;

    assign w_op     = opcode_e'(r_cmd[CMD_W-1 -: 2]);
    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and frame outputs. SS_n/MOSI decode straight from the
    // registered state so a reset edge releases the bus at that edge.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        cmd_ready    = 1'b0;
        busy         = 1'b1;
        SS_n         = 1'b0;
        MOSI         = 1'b0;
        w_accept     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                SS_n      = 1'b1;
                if (cmd_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                // MOSI pre-drives the first bit during the slave's check cycle.
                MOSI = r_cmd[CMD_W-1];
                if (r_gap_cnt == c_gap_last) begin
                    w_state_next = ST_SHIFT_OUT;
                end
            end
            ST_SHIFT_OUT: begin
                MOSI = r_cmd[c_out_last - r_bit_cnt];
                if (r_bit_cnt == c_out_last) begin
                    w_state_next = (w_op == RD_DATA) ? ST_WAIT_RD : ST_END;
                end
            end
            ST_WAIT_RD: begin
                if (r_gap_cnt == c_lat_last) begin
                    w_state_next = ST_SHIFT_IN;
                end
            end
            ST_SHIFT_IN: begin
                if (r_bit_cnt == c_in_last) begin
                    w_state_next = ST_END;
                end
            end
            ST_END: begin
                SS_n = 1'b1;
                if (r_gap_cnt == c_idle_last) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: command capture, phase counters, MISO capture.
    // Both counters restart on every state change so each phase counts
    // from zero regardless of how the previous phase ended.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cmd      <= '0;
            r_gap_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_shift_in <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cmd <= cmd_data;
            end

            if (w_state_next != r_state) begin
                r_gap_cnt <= '0;
                r_bit_cnt <= '0;
            end else begin
                if (r_state inside {ST_START, ST_WAIT_RD, ST_END}) begin
                    r_gap_cnt <= r_gap_cnt + 1'b1;
                end
                if (r_state inside {ST_SHIFT_OUT, ST_SHIFT_IN}) begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end

            r_rd_valid <= 1'b0;
            if (r_state == ST_SHIFT_IN) begin
                r_shift_in <= {r_shift_in[DATA_W-2:0], MISO};
                // Last sample goes straight into rd_data so the pulse lines
                // up with the first END cycle.
                if (r_bit_cnt == c_in_last) begin
                    r_rd_data  <= {r_shift_in[DATA_W-2:0], MISO};
                    r_rd_valid <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Protocol properties
    // ------------------------------------------------------------------
    a_ss_low_in_shift: assert property (@(posedge clk) disable iff (!rst_n)
        (r_state inside {ST_SHIFT_OUT, ST_SHIFT_IN}) |-> !SS_n);

    a_rd_valid_pulse: assert property (@(posedge clk) disable iff (!rst_n)
        rd_valid |=> !rd_valid);

    a_rd_valid_op: assert property (@(posedge clk) disable iff (!rst_n)
        rd_valid |-> (w_op == RD_DATA));

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_master
//  Description : Self-checking bench for spi_master. Instance 0 uses the
//                default parameters, instance 1 uses RD_LATENCY=3. A
//                behavioural slave/RAM answers read-data frames; a negedge
//                monitor records frames and read pulses; expected words and
//                reply bytes are queued at stimulus time and compared later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master;
    import spi_pkg::*;

    typedef struct {
        int         len;
        logic [9:0] word;
        logic       start_bit;
        int         hi_gap;
    } frame_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      cmd_valid;
    logic [1:0][9:0] cmd_data;
    logic [1:0]      cmd_ready;
    logic [1:0]      miso;
    logic [1:0]      mosi;
    logic [1:0]      ss_n;
    logic [1:0]      rd_valid;
    logic [1:0][7:0] rd_data;
    logic [1:0]      busy;

    int errors = 0;
    int checks = 0;

    logic [9:0] exp_w_q [2][$];
    logic [7:0] exp_r_q [2][$];
    frame_t     frm_q   [2][$];
    logic [7:0] rd_q    [2][$];
    int         rdv_cnt [2] = '{0, 0};

    always #5 clk = ~clk;

    spi_master #(.GAP_CYCLES(1), .RD_LATENCY(2), .IDLE_GAP(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid[0]), .cmd_data(cmd_data[0]), .cmd_ready(cmd_ready[0]),
        .MISO(miso[0]), .MOSI(mosi[0]), .SS_n(ss_n[0]),
        .rd_valid(rd_valid[0]), .rd_data(rd_data[0]), .busy(busy[0])
    );

    spi_master #(.GAP_CYCLES(1), .RD_LATENCY(3), .IDLE_GAP(1)) u_dut_lat3 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid[1]), .cmd_data(cmd_data[1]), .cmd_ready(cmd_ready[1]),
        .MISO(miso[1]), .MOSI(mosi[1]), .SS_n(ss_n[1]),
        .rd_valid(rd_valid[1]), .rd_data(rd_data[1]), .busy(busy[1])
    );

    // ---------------- behavioural slave/RAM (posedge) ----------------
    // Cycle 0 of a frame is the check cycle, cycles 1..10 carry the command,
    // reply bits occupy cycles 11+LAT .. 18+LAT.
    int         sl_k    [2] = '{0, 0};
    logic [9:0] sl_sh   [2];
    logic [7:0] sl_waddr[2];
    logic [7:0] sl_raddr[2];
    logic [7:0] sl_reply[2];
    logic [7:0] sl_mem  [2][256];
    logic [9:0] sl_nw;
    int         sl_bi;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (ss_n[i] === 1'b0) begin
                sl_nw = {sl_sh[i][8:0], mosi[i]};
                if (sl_k[i] >= 1 && sl_k[i] <= 10) sl_sh[i] = sl_nw;
                if (sl_k[i] == 10) begin
                    case (sl_sh[i][9:8])
                        2'b00:   sl_waddr[i] = sl_sh[i][7:0];
                        2'b01:   sl_mem[i][sl_waddr[i]] = sl_sh[i][7:0];
                        2'b10:   sl_raddr[i] = sl_sh[i][7:0];
                        default: sl_reply[i] = sl_mem[i][sl_raddr[i]];
                    endcase
                end
                sl_k[i]++;
                sl_bi = sl_k[i] - 11 - ((i == 0) ? 2 : 3);
                if (sl_bi >= 0 && sl_bi < 8) miso[i] <= sl_reply[i][7 - sl_bi];
                else                         miso[i] <= 1'b0;
            end else begin
                sl_k[i] = 0;
                miso[i] <= 1'b0;
            end
        end
    end

    // ---------------- monitor (negedge) ----------------
    int         mon_len  [2] = '{0, 0};
    int         mon_hi   [2] = '{1000, 1000};
    int         mon_gap  [2] = '{0, 0};
    logic [9:0] mon_word [2];
    logic       mon_start[2];
    frame_t     mon_f;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (ss_n[i] === 1'b0) begin
                if (mon_len[i] == 0) begin
                    mon_gap[i]   = mon_hi[i];
                    mon_start[i] = mosi[i];
                    mon_word[i]  = '0;
                end else if (mon_len[i] <= 10) begin
                    mon_word[i] = {mon_word[i][8:0], mosi[i]};
                end
                mon_len[i]++;
                mon_hi[i] = 0;
            end else begin
                if (mon_len[i] > 0) begin
                    mon_f.len       = mon_len[i];
                    mon_f.word      = mon_word[i];
                    mon_f.start_bit = mon_start[i];
                    mon_f.hi_gap    = mon_gap[i];
                    frm_q[i].push_back(mon_f);
                end
                mon_len[i] = 0;
                mon_hi[i]++;
            end
            if (rd_valid[i] === 1'b1) begin
                rd_q[i].push_back(rd_data[i]);
                rdv_cnt[i]++;
            end
        end
    end

    // Expected SS_n-low length with GAP_CYCLES=1.
    function automatic int exp_len(input int idx, input logic [9:0] w);
        if (w[9:8] != 2'b11) return 11;
        return (idx == 0) ? 21 : 22;
    endfunction

    task automatic send(input int idx, input logic [9:0] w);
        int t = 0;
        @(negedge clk);
        cmd_valid[idx] = 1'b1;
        cmd_data[idx]  = w;
        while (cmd_ready[idx] !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            checks++; errors++;
            $display("FAIL accept_timeout: cmd_ready=%b required 1", cmd_ready[idx]);
        end
        @(posedge clk);
        #1;
        cmd_valid[idx] = 1'b0;
        cmd_data[idx]  = ~w;
        exp_w_q[idx].push_back(w);
    endtask

    task automatic wait_idle(input int idx);
        int t = 0;
        @(negedge clk);
        while (busy[idx] !== 1'b0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            checks++; errors++;
            $display("FAIL idle_timeout: busy=%b required 0", busy[idx]);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++; if (ss_n[i] !== 1'b1)      begin errors++; $display("FAIL reset_ss_n[%0d]: got %b required 1", i, ss_n[i]); end
            checks++; if (mosi[i] !== 1'b0)      begin errors++; $display("FAIL reset_mosi[%0d]: got %b required 0", i, mosi[i]); end
            checks++; if (rd_valid[i] !== 1'b0)  begin errors++; $display("FAIL reset_rd_valid[%0d]: got %b required 0", i, rd_valid[i]); end
            checks++; if (rd_data[i] !== 8'h00)  begin errors++; $display("FAIL reset_rd_data[%0d]: got %h required 00", i, rd_data[i]); end
            checks++; if (busy[i] !== 1'b0)      begin errors++; $display("FAIL reset_busy[%0d]: got %b required 0", i, busy[i]); end
            checks++; if (cmd_ready[i] !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready[%0d]: got %b required 1", i, cmd_ready[i]); end
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write_addr();
        int         base = rdv_cnt[0];
        logic [9:0] ew;
        frame_t     f;
        send(0, 10'h0A5);
        wait_idle(0);
        while (exp_w_q[0].size() > 0) begin
            ew = exp_w_q[0].pop_front();
            checks++;
            if (frm_q[0].size() == 0) begin
                errors++; $display("FAIL wr_addr_frame: no frame, required word %h", ew);
            end else begin
                f = frm_q[0].pop_front();
                if (f.word !== ew || f.start_bit !== ew[9] || f.len !== exp_len(0, ew)) begin
                    errors++;
                    $display("FAIL wr_addr_frame: word=%h start=%b len=%0d required word=%h start=%b len=%0d",
                             f.word, f.start_bit, f.len, ew, ew[9], exp_len(0, ew));
                end
            end
        end
        checks++;
        if (rdv_cnt[0] !== base) begin
            errors++; $display("FAIL wr_addr_no_rd: rd_valid pulses=%0d required 0", rdv_cnt[0] - base);
        end
    endtask

    // Sends a write/read-back sequence to one instance and checks every
    // frame plus exactly one reply of the given value.
    task automatic test_readback(input int idx, input logic [7:0] addr, input logic [7:0] val);
        int         base = rdv_cnt[idx];
        logic [9:0] ew;
        logic [7:0] er;
        logic [7:0] got;
        frame_t     f;
        send(idx, {2'b00, addr});
        send(idx, {2'b01, val});
        send(idx, {2'b10, addr});
        exp_r_q[idx].push_back(val);
        send(idx, 10'h300);
        wait_idle(idx);
        while (exp_w_q[idx].size() > 0) begin
            ew = exp_w_q[idx].pop_front();
            checks++;
            if (frm_q[idx].size() == 0) begin
                errors++; $display("FAIL readback_frame[%0d]: no frame, required word %h", idx, ew);
            end else begin
                f = frm_q[idx].pop_front();
                if (f.word !== ew || f.start_bit !== ew[9] || f.len !== exp_len(idx, ew)) begin
                    errors++;
                    $display("FAIL readback_frame[%0d]: word=%h start=%b len=%0d required word=%h start=%b len=%0d",
                             idx, f.word, f.start_bit, f.len, ew, ew[9], exp_len(idx, ew));
                end
            end
        end
        checks++;
        if (rdv_cnt[idx] - base !== 1) begin
            errors++; $display("FAIL readback_pulses[%0d]: got %0d required 1", idx, rdv_cnt[idx] - base);
        end
        while (exp_r_q[idx].size() > 0) begin
            er = exp_r_q[idx].pop_front();
            got = (rd_q[idx].size() > 0) ? rd_q[idx].pop_front() : 8'hxx;
            checks++;
            if (got !== er) begin
                errors++; $display("FAIL readback_data[%0d]: got %h required %h", idx, got, er);
            end
        end
        rd_q[idx].delete();
        repeat (5) @(negedge clk);
        checks++;
        if (rd_data[idx] !== val) begin
            errors++; $display("FAIL rd_data_hold[%0d]: got %h required %h", idx, rd_data[idx], val);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] words [3] = '{10'h055, 10'h1AA, 10'h2F0};
        logic [9:0] ew;
        frame_t     f;
        int         n = 0;
        int         t;
        @(negedge clk);
        cmd_valid[0] = 1'b1;
        cmd_data[0]  = words[0];
        for (int j = 0; j < 3; j++) begin
            t = 0;
            while (cmd_ready[0] !== 1'b1 && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (t >= 200) begin
                checks++; errors++; $display("FAIL b2b_accept_timeout: word %0d", j);
            end
            @(posedge clk);
            #1;
            exp_w_q[0].push_back(words[j]);
            if (j < 2) cmd_data[0] = words[j+1];
            else begin
                cmd_valid[0] = 1'b0;
                cmd_data[0]  = 10'h3FF;
            end
        end
        wait_idle(0);
        while (exp_w_q[0].size() > 0) begin
            ew = exp_w_q[0].pop_front();
            checks++;
            if (frm_q[0].size() == 0) begin
                errors++; $display("FAIL b2b_frame: no frame, required word %h", ew);
            end else begin
                f = frm_q[0].pop_front();
                if (f.word !== ew || f.len !== 11 || (n > 0 && f.hi_gap < 2)) begin
                    errors++;
                    $display("FAIL b2b_frame: word=%h len=%0d gap=%0d required word=%h len=11 gap>=2",
                             f.word, f.len, f.hi_gap, ew);
                end
            end
            n++;
        end
        checks++;
        if (frm_q[0].size() != 0) begin
            errors++; $display("FAIL b2b_extra_frames: got %0d required 0", frm_q[0].size());
            frm_q[0].delete();
        end
    endtask

    task automatic test_cmd_data_change();
        int         base = rdv_cnt[0];
        logic [9:0] ew;
        logic [7:0] got;
        frame_t     f;
        send(0, 10'h007);
        send(0, 10'h1C5);
        send(0, 10'h207);
        exp_r_q[0].push_back(8'hC5);
        send(0, 10'h300);
        repeat (6) @(negedge clk);
        cmd_data[0] = 10'h0FF;
        wait_idle(0);
        while (exp_w_q[0].size() > 0) begin
            ew = exp_w_q[0].pop_front();
            checks++;
            if (frm_q[0].size() == 0) begin
                errors++; $display("FAIL data_change_frame: no frame, required word %h", ew);
            end else begin
                f = frm_q[0].pop_front();
                if (f.word !== ew || f.len !== exp_len(0, ew)) begin
                    errors++;
                    $display("FAIL data_change_frame: word=%h len=%0d required word=%h len=%0d",
                             f.word, f.len, ew, exp_len(0, ew));
                end
            end
        end
        got = (rd_q[0].size() > 0) ? rd_q[0].pop_front() : 8'hxx;
        checks++;
        if (rdv_cnt[0] - base !== 1 || got !== exp_r_q[0].pop_front()) begin
            errors++; $display("FAIL data_change_rd: pulses=%0d data=%h required 1 pulse data=c5", rdv_cnt[0] - base, got);
        end
        rd_q[0].delete();
    endtask

    task automatic test_reset_mid_frame();
        int     base;
        frame_t f;
        send(0, 10'h300);
        exp_w_q[0].delete();
        base = rdv_cnt[0];
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (ss_n[0] !== 1'b1)      begin errors++; $display("FAIL midrst_ss_n: got %b required 1", ss_n[0]); end
        checks++; if (mosi[0] !== 1'b0)      begin errors++; $display("FAIL midrst_mosi: got %b required 0", mosi[0]); end
        checks++; if (busy[0] !== 1'b0)      begin errors++; $display("FAIL midrst_busy: got %b required 0", busy[0]); end
        checks++; if (cmd_ready[0] !== 1'b1) begin errors++; $display("FAIL midrst_cmd_ready: got %b required 1", cmd_ready[0]); end
        checks++; if (rd_data[0] !== 8'h00)  begin errors++; $display("FAIL midrst_rd_data: got %h required 00", rd_data[0]); end
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        checks++;
        if (frm_q[0].size() != 1) begin
            errors++; $display("FAIL midrst_frames: got %0d required 1", frm_q[0].size());
        end else begin
            f = frm_q[0].pop_front();
            if (f.len !== 6) begin
                errors++; $display("FAIL midrst_frames: aborted frame len=%0d required 6", f.len);
            end
        end
        frm_q[0].delete();
        checks++;
        if (rdv_cnt[0] !== base) begin
            errors++; $display("FAIL midrst_no_rd: rd_valid pulses=%0d required 0", rdv_cnt[0] - base);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = '0;
        cmd_data  = '0;
        miso      = '0;
        test_reset();
        test_write_addr();
        test_readback(0, 8'h12, 8'h3C);
        test_readback(0, 8'h40, 8'h81);
        test_readback(1, 8'h40, 8'h81);
        test_back_to_back();
        test_cmd_data_change();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/spi_master.md
Name: spi_master

Overview:
- SPI initiator that drives the single-clock SPI slave/RAM wrapper from the master side.
- Accepts 10-bit command words (opcode[9:8] + payload[7:0]) from a host through a valid/ready handshake.
- Frames each word on SS_n/MOSI, MSB first.
- For read-data commands (opcode 2'b11), captures the 8-bit MISO reply and returns it to the host with a one-cycle valid pulse.

Parameters:
- GAP_CYCLES, default 1: cycles SS_n is held low, with MOSI = cmd[9], before the 10-bit shift. This covers the slave's command-check cycle.
- RD_LATENCY, default 2: cycles between the last MOSI bit and the first MISO sample on a read-data frame.
- IDLE_GAP, default 1: minimum cycles SS_n is held high between frames.

Ports:
- clk, input, 1: clock; all logic on posedge.
- rst_n, input, 1: synchronous, active-low reset.
- cmd_valid, input, 1: host presents a command.
- cmd_data, input, 10: command word; [9:8] opcode, [7:0] address/data.
- cmd_ready, output, 1: high only in IDLE; a command is accepted when cmd_valid && cmd_ready on a posedge.
- MISO, input, 1: serial data from slave.
- MOSI, output, 1: serial data to slave.
- SS_n, output, 1: active-low frame select.
- rd_valid, output, 1: one-cycle pulse; rd_data is valid in that cycle.
- rd_data, output, 8: byte captured from MISO, MSB first.
- busy, output, 1: high in every state except IDLE.

Behaviour:
- Reset (rst_n low at posedge) forces, at that edge:
  - state IDLE, SS_n=1, MOSI=0, rd_valid=0, rd_data=0, busy=0, cmd_ready=1.
  - All counters cleared; any command register cleared.
  - Reset mid-frame aborts the frame: SS_n rises at that edge and no rd_valid is ever issued for the aborted frame.
- On acceptance, cmd_data is registered; later changes on cmd_data have no effect on the frame.
- States: IDLE -> START -> SHIFT_OUT -> (WAIT_RD -> SHIFT_IN ->) END -> IDLE.
- IDLE: SS_n=1, MOSI=0. Accepting a command moves to START at the same edge.
- START: SS_n=0, MOSI=cmd[9], for GAP_CYCLES cycles.
- SHIFT_OUT: exactly 10 cycles; MOSI=cmd[9-i] in the i-th cycle; SS_n=0.
- Leaving SHIFT_OUT:
  - opcode != 2'b11 -> END.
  - opcode == 2'b11 -> WAIT_RD.
- WAIT_RD: SS_n=0, MOSI=0, for RD_LATENCY cycles.
- SHIFT_IN: 8 cycles; MISO sampled each posedge into a shift register (first sample -> bit 7); SS_n=0, MOSI=0.
- Last SHIFT_IN edge: rd_data loads the full byte; rd_valid=1 for exactly the following cycle; state -> END.
- END: SS_n=1, MOSI=0, for IDLE_GAP cycles, then IDLE.
- cmd_ready rises again only after END completes, so back-to-back frames are separated by at least IDLE_GAP+1 SS_n-high cycles. The +1 is the IDLE acceptance cycle.
- Frame length (SS_n-low cycles):
  - Write/address frames: GAP_CYCLES+10.
  - Read-data frames: GAP_CYCLES+10+RD_LATENCY+8.
- rd_data holds its value until the next read-data frame completes or reset.
- Counters:
  - Bit counter: 4 bits, counts 0..9 in SHIFT_OUT and 0..7 in SHIFT_IN, cleared on every state entry.
  - Gap/latency counter: width $clog2(max(GAP_CYCLES,RD_LATENCY,IDLE_GAP)+1).
  - Parameters of 0 are illegal; elaborate-time assertion.
- cmd_valid while busy is ignored (cmd_ready=0); the host must hold it.
- Assertions:
  - SS_n never toggles inside SHIFT_OUT/SHIFT_IN.
  - rd_valid is never high two consecutive cycles.
  - rd_valid only follows a frame with opcode 2'b11.

Decomposition:
- Shared package spi_pkg, holding:
  - opcode enum: WR_ADDR=2'b00, WR_DATA=2'b01, RD_ADDR=2'b10, RD_DATA=2'b11.
  - master state enum.
  - constants CMD_W=10 and DATA_W=8.
- Single module; the shift registers and counters are small enough to stay inline. No sub-module.

Test Plan:
- Reset mid-SHIFT_OUT: rst_n=0 on the 5th shift cycle -> next edge SS_n=1, MOSI=0, busy=0, cmd_ready=1; no rd_valid afterwards.
- Write address: cmd_data=10'h0A5 (op 00, A5) -> SS_n low 11 cycles (GAP=1), MOSI sequence after the START bit 0 = 0,0,1,0,1,0,0,1,0,1; no rd_valid.
- Write + read-back with behavioural slave/RAM: send 10'h012, 10'h13C, 10'h212, 10'h300 -> single rd_valid pulse with rd_data=8'h3C; read frame SS_n-low length 21 cycles (1+10+2+8).
- MISO pattern: slave model drives 8'b1000_0001 on a read-data frame -> rd_data=8'h81.
  - Repeat with RD_LATENCY=3 -> same data, SS_n-low 22 cycles.
- Handshake back-pressure: cmd_valid held high with 3 queued words -> each accepted only when cmd_ready=1; at least 2 SS_n-high cycles between frames; words are transmitted in order.
- cmd_data changes during a frame -> transmitted bits match the accepted word.
